shift_engine: RTL and testbench
===============================

SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter ancho, default 8, data width in bits; SHALL be a power of two, >= 4.
REQ-002 Parameter ANCHO_B, default 4, shift-amount width in bits; SHALL be >= log2(ancho)+1.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  engine idle and accepting a request.
REQ-008 a  input  ancho  operand to shift.
REQ-009 b  input  ANCHO_B  unsigned shift amount.
REQ-010 op  input  2  mode: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
REQ-011 aluflagin  input  1  fill bit shifted in for LSL and LSR; ignored for ASR and ROL.
REQ-012 out_valid  output  1  result and flags valid.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 aluresult  output  ancho  shifted result, registered.
REQ-015 carry  output  1  last bit shifted or rotated out; 0 when the effective count is 0.
REQ-016 zero  output  1  aluresult == 0.

Function
REQ-017 FSM states are IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 Accept occurs on a rising edge with in_valid=1 in IDLE; a, b, op and aluflagin are captured at accept, and later input changes have no effect.
REQ-019 Effective count n: for LSL/LSR/ASR, n = min(b, ancho); for ROL, n = b mod ancho.
REQ-020 At accept: if n=0, go to DONE with aluresult=a and carry=0; otherwise go to SHIFT with count=n.
REQ-021 In SHIFT, perform one 1-bit step per cycle and decrement count; on the step where count reaches 0, go to DONE.
REQ-022 LSL step: result = {r[ancho-2:0], aluflagin}; carry = r[ancho-1].
REQ-023 LSR step: result = {aluflagin, r[ancho-1:1]}; carry = r[0].
REQ-024 ASR step: result = {r[ancho-1], r[ancho-1:1]}; carry = r[0].
REQ-025 ROL step: result = {r[ancho-2:0], r[ancho-1]}; carry = r[ancho-1].
REQ-026 Latency: out_valid SHALL rise n+1 cycles after the accept edge.
REQ-027 In DONE, out_valid=1; aluresult, carry and zero SHALL hold stable until the cycle with out_ready=1, then return to IDLE on the next edge.
REQ-028 in_valid outside IDLE SHALL be ignored; there is no queuing.
REQ-029 zero SHALL be updated together with aluresult and SHALL never be stale relative to it.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, aluresult=0, carry=0, zero=1, out_valid=0, count=0; in_ready=1 after reset.
REQ-031 Reset during SHIFT or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-032 Macro SHIFT_ENGINE_OVF_EN: when defined, add output ovf (1 bit), and ovf is reset to 0.
REQ-033 ovf SHALL be 1 if any LSL step changed bit ancho-1 of the running result; it is 0 for other modes.
REQ-034 ovf is valid with out_valid and has the same hold rules as carry.
REQ-035 Without SHIFT_ENGINE_OVF_EN, the ovf port and its logic are absent; all other behaviour is identical.

Verification (ancho=8, ANCHO_B=4)
REQ-036 LSL: a=0x81, b=1, aluflagin=0 -> aluresult=0x02, carry=1, zero=0, out_valid 2 cycles after accept; ovf=1 when SHIFT_ENGINE_OVF_EN is defined.
REQ-037 LSR: a=0x0F, b=4, aluflagin=1 -> aluresult=0xF0, carry=1, out_valid 5 cycles after accept.
REQ-038 ASR: a=0x80, b=9 (saturates to n=8) -> aluresult=0xFF, carry=1, out_valid 9 cycles after accept; LSR with a=0x80, b=15, aluflagin=0 -> 0x00, zero=1.
REQ-039 ROL: a=0x81, b=9 (n=1) -> aluresult=0x03, carry=1, out_valid 2 cycles after accept.
REQ-040 b=0, a=0x5A, out_ready held 0 for 3 cycles -> out_valid 1 cycle after accept, aluresult=0x5A, carry=0, outputs stable; a second in_valid during this time is ignored (in_ready=0).
REQ-041 Assert rst mid-SHIFT -> all outputs reach their reset values immediately, no out_valid, in_ready=1 after release; the next request completes correctly.

Source files
------------

// File: rtl/shift_engine.sv
// Iterative 1-bit-per-cycle shifter: LSL, LSR, ASR, ROL with valid/ready handshake.
// Optional ovf output enabled by defining SHIFT_ENGINE_OVF_EN.
module shift_engine #(
  parameter int ancho   = 8,
  parameter int ANCHO_B = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ancho-1:0]   a,
  input  logic [ANCHO_B-1:0] b,
  input  logic [1:0]         op,
  input  logic               aluflagin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ancho-1:0]   aluresult,
  output logic               carry,
  output logic               zero
`ifdef SHIFT_ENGINE_OVF_EN
  ,
  output logic               ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam logic [ANCHO_B-1:0] W    = ANCHO_B'(ancho);
  localparam logic [ANCHO_B-1:0] MASK = W - ANCHO_B'(1);

  state_t state_q, state_d;

  logic [ancho-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic [ANCHO_B-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               flag_q, flag_d;
`ifdef SHIFT_ENGINE_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [ANCHO_B-1:0] n_c;
  logic [ancho-1:0]   step_r;
  logic               step_c;
  logic               accept;

  assign accept = (state_q == IDLE) && in_valid;

  // Effective count: shifts saturate at ancho, rotates wrap modulo ancho.
  always_comb begin
    if (op == OP_ROL) begin
      n_c = b & MASK;
    end else begin
      n_c = (b > W) ? W : b;
    end
  end

  // One 1-bit step of the captured operation on the running result.
  always_comb begin
    unique case (op_q)
      OP_LSL: begin
        step_r = {res_q[ancho-2:0], flag_q};
        step_c = res_q[ancho-1];
      end
      OP_LSR: begin
        step_r = {flag_q, res_q[ancho-1:1]};
        step_c = res_q[0];
      end
      OP_ASR: begin
        step_r = {res_q[ancho-1], res_q[ancho-1:1]};
        step_c = res_q[0];
      end
      default: begin
        step_r = {res_q[ancho-2:0], res_q[ancho-1]};
        step_c = res_q[ancho-1];
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (n_c == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == ANCHO_B'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next state: load at accept, step while shifting, hold otherwise.
  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    flag_d  = flag_q;
`ifdef SHIFT_ENGINE_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      res_d   = a;
      carry_d = 1'b0;
      zero_d  = (a == '0);
      cnt_d   = n_c;
      op_d    = op;
      flag_d  = aluflagin;
`ifdef SHIFT_ENGINE_OVF_EN
      ovf_d   = 1'b0;
`endif
    end else if (state_q == SHIFT) begin
      res_d   = step_r;
      carry_d = step_c;
      zero_d  = (step_r == '0);
      cnt_d   = cnt_q - ANCHO_B'(1);
`ifdef SHIFT_ENGINE_OVF_EN
      if (op_q == OP_LSL) begin
        ovf_d = ovf_q | (res_q[ancho-1] ^ res_q[ancho-2]);
      end
`endif
    end
  end

  // Datapath registers; zero is registered with the result so it never lags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      cnt_q   <= '0;
      op_q    <= OP_LSL;
      flag_q  <= 1'b0;
`ifdef SHIFT_ENGINE_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      flag_q  <= flag_d;
`ifdef SHIFT_ENGINE_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign aluresult = res_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
`ifdef SHIFT_ENGINE_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_shift_engine.sv
// Directed self-checking bench for shift_engine (ancho=8, ANCHO_B=4).
// Covers all modes, saturation/wrap, hold, ignored requests and reset abort.
module tb_shift_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [3:0] b = '0;
  logic [1:0] op = '0;
  logic       aluflagin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] aluresult;
  logic       carry;
  logic       zero;
`ifdef SHIFT_ENGINE_OVF_EN
  logic       ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  shift_engine #(.ancho(8), .ANCHO_B(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .op(op),
    .aluflagin(aluflagin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .aluresult(aluresult),
    .carry(carry),
    .zero(zero)
`ifdef SHIFT_ENGINE_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus only: accept one request, scramble inputs afterwards, and
  // report the latency k such that out_valid is seen just before edge k
  // (accept edge is edge 0). Leaves the bench at a negedge.
  task automatic issue(input logic [7:0] ta, input logic [3:0] tb,
                       input logic [1:0] top, input logic tf,
                       output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = ta; b = tb; op = top; aluflagin = tf;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb; op = ~top; aluflagin = ~tf;
    lat = 0;
    while (lat < 40) begin
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++;
    if (aluresult !== 8'h00 || carry !== 1'b0 || zero !== 1'b1 ||
        out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: res=%h c=%b z=%b ov=%b ir=%b want 00 0 1 0 1",
               aluresult, carry, zero, out_valid, in_ready);
    end
`ifdef SHIFT_ENGINE_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lsl();
    int lat;
    issue(8'h81, 4'd1, 2'b00, 1'b0, lat);
    n_cmp++;
    if (aluresult !== 8'h02 || carry !== 1'b1 || zero !== 1'b0 || lat != 2) begin
      n_bad++;
      $display("FAIL lsl: res=%h c=%b z=%b lat=%0d want 02 1 0 2",
               aluresult, carry, zero, lat);
    end
`ifdef SHIFT_ENGINE_OVF_EN
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL lsl_ovf: got %b want 1", ovf);
    end
`endif
    consume();
    issue(8'h40, 4'd2, 2'b00, 1'b1, lat);
    n_cmp++;
    if (aluresult !== 8'h03 || carry !== 1'b1 || lat != 3) begin
      n_bad++;
      $display("FAIL lsl_fill: res=%h c=%b lat=%0d want 03 1 3",
               aluresult, carry, lat);
    end
`ifdef SHIFT_ENGINE_OVF_EN
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL lsl_fill_ovf: got %b want 1", ovf);
    end
`endif
    consume();
  endtask

  task automatic test_lsr();
    int lat;
    issue(8'h0F, 4'd4, 2'b01, 1'b1, lat);
    n_cmp++;
    if (aluresult !== 8'hF0 || carry !== 1'b1 || zero !== 1'b0 || lat != 5) begin
      n_bad++;
      $display("FAIL lsr: res=%h c=%b z=%b lat=%0d want F0 1 0 5",
               aluresult, carry, zero, lat);
    end
`ifdef SHIFT_ENGINE_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL lsr_ovf: got %b want 0", ovf);
    end
`endif
    consume();
    issue(8'h80, 4'd15, 2'b01, 1'b0, lat);
    n_cmp++;
    if (aluresult !== 8'h00 || zero !== 1'b1 || carry !== 1'b1 || lat != 9) begin
      n_bad++;
      $display("FAIL lsr_sat: res=%h z=%b c=%b lat=%0d want 00 1 1 9",
               aluresult, zero, carry, lat);
    end
    consume();
  endtask

  task automatic test_asr();
    int lat;
    issue(8'h80, 4'd9, 2'b10, 1'b0, lat);
    n_cmp++;
    if (aluresult !== 8'hFF || carry !== 1'b1 || zero !== 1'b0 || lat != 9) begin
      n_bad++;
      $display("FAIL asr_sat: res=%h c=%b z=%b lat=%0d want FF 1 0 9",
               aluresult, carry, zero, lat);
    end
    consume();
    issue(8'h46, 4'd2, 2'b10, 1'b1, lat);
    n_cmp++;
    if (aluresult !== 8'h11 || carry !== 1'b1 || lat != 3) begin
      n_bad++;
      $display("FAIL asr_pos: res=%h c=%b lat=%0d want 11 1 3",
               aluresult, carry, lat);
    end
    consume();
  endtask

  task automatic test_rol();
    int lat;
    issue(8'h81, 4'd9, 2'b11, 1'b0, lat);
    n_cmp++;
    if (aluresult !== 8'h03 || carry !== 1'b1 || lat != 2) begin
      n_bad++;
      $display("FAIL rol_wrap: res=%h c=%b lat=%0d want 03 1 2",
               aluresult, carry, lat);
    end
    consume();
    issue(8'h3C, 4'd8, 2'b11, 1'b0, lat);
    n_cmp++;
    if (aluresult !== 8'h3C || carry !== 1'b0 || lat != 1) begin
      n_bad++;
      $display("FAIL rol_full: res=%h c=%b lat=%0d want 3C 0 1",
               aluresult, carry, lat);
    end
    consume();
  endtask

  task automatic test_hold();
    int lat;
    issue(8'h5A, 4'd0, 2'b00, 1'b0, lat);
    n_cmp++;
    if (aluresult !== 8'h5A || carry !== 1'b0 || zero !== 1'b0 || lat != 1) begin
      n_bad++;
      $display("FAIL zero_cnt: res=%h c=%b z=%b lat=%0d want 5A 0 0 1",
               aluresult, carry, zero, lat);
    end
    a = 8'h01; b = 4'd3; op = 2'b00;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (aluresult !== 8'h5A || carry !== 1'b0 || out_valid !== 1'b1 ||
          in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold%0d: res=%h c=%b ov=%b ir=%b want 5A 0 1 0",
                 i, aluresult, carry, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    consume();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || aluresult !== 8'h5A) begin
      n_bad++;
      $display("FAIL no_queue: ov=%b ir=%b res=%h want 0 1 5A",
               out_valid, in_ready, aluresult);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    int seen;
    @(negedge clk);
    a = 8'h80; b = 4'd8; op = 2'b10; aluflagin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (aluresult !== 8'h00 || carry !== 1'b0 || zero !== 1'b1 ||
        out_valid !== 1'b0 || seen != 0) begin
      n_bad++;
      $display("FAIL rst_abort: res=%h c=%b z=%b ov=%b seen=%0d want 00 0 1 0 0",
               aluresult, carry, zero, out_valid, seen);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_release: ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
    issue(8'h81, 4'd1, 2'b00, 1'b0, lat);
    n_cmp++;
    if (aluresult !== 8'h02 || carry !== 1'b1 || lat != 2) begin
      n_bad++;
      $display("FAIL post_rst: res=%h c=%b lat=%0d want 02 1 2",
               aluresult, carry, lat);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_lsr();
    test_asr();
    test_rol();
    test_hold();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
